// File: rtl/mem_msg_pkg.sv
// Shared request-message layout and routing constants for the cache-miss request path.
package mem_msg_pkg;

  localparam int unsigned MSG_W = 48;

  // Message layout: {dest[1:0], 1, src[1:0], 0, cmd[4:0], 5'b0, addr[31:0]}
  localparam int unsigned DEST_HI = 47;
  localparam int unsigned DEST_LO = 46;
  localparam int unsigned SRC_HI  = 44;
  localparam int unsigned SRC_LO  = 43;
  localparam int unsigned CMD_HI  = 41;
  localparam int unsigned CMD_LO  = 37;
  localparam int unsigned ADDR_HI = 31;
  localparam int unsigned ADDR_LO = 0;

  localparam logic [1:0] LOCAL_ID = 2'b00;

  localparam logic [4:0] INSTREQ_CMD = 5'b00110;

  // Requester index; also the bit position in the arbiter request/grant vectors.
  typedef enum logic {
    ReqIc = 1'b0,
    ReqDc = 1'b1
  } req_e;

  function automatic logic [1:0] msg_dest(input logic [MSG_W-1:0] msg);
    return msg[DEST_HI:DEST_LO];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer only moves when a grant is issued.
module rr_arb2
  import mem_msg_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  req_e prio_q, prio_d;

  // Grant: a lone request wins outright, a tie goes to the favoured requester.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) begin
        gnt_o = (prio_q == ReqIc) ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
    end
  end

  // Next favoured requester is the one not just granted.
  always_comb begin
    prio_d = prio_q;
    if (gnt_o[ReqIc]) begin
      prio_d = ReqDc;
    end else if (gnt_o[ReqDc]) begin
      prio_d = ReqIc;
    end
  end

  // Pointer register, IC favoured out of reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prio_q <= ReqIc;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Captures IC/DC miss-request pulses into holding slots and round-robins them onto the
// local-memory and OUT_req upload channels through registered valid/ready outputs.
module mem_req_arbiter #(
  parameter int unsigned MSG_W    = 48,
  parameter logic [1:0]  LOCAL_ID = 2'b00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             v_ic_req,
  input  logic [MSG_W-1:0] ic_req_msg,
  input  logic             v_dc_req,
  input  logic [MSG_W-1:0] dc_req_msg,
  output logic             v_local_req,
  output logic [MSG_W-1:0] local_req_msg,
  input  logic             local_ready,
  output logic             v_out_req,
  output logic [MSG_W-1:0] out_req_msg,
  input  logic             out_ready,
  output logic             ic_pending,
  output logic             dc_pending,
  output logic             ovf_err
);

  import mem_msg_pkg::*;

  logic             ic_v_q, ic_loc_q, dc_v_q, dc_loc_q;
  logic [MSG_W-1:0] ic_msg_q, dc_msg_q;
  logic             loc_v_q, out_v_q, ovf_q;
  logic [MSG_W-1:0] loc_msg_q, out_msg_q;

  logic [1:0] loc_req, out_req, loc_gnt, out_gnt;
  logic       loc_en, out_en, ic_gnt, dc_gnt;

  // Route on the message's own dest field captured in the slot.
  assign loc_req = {dc_v_q &  dc_loc_q, ic_v_q &  ic_loc_q};
  assign out_req = {dc_v_q & ~dc_loc_q, ic_v_q & ~ic_loc_q};

  // An output register may load when empty or when it is transferring this cycle.
  assign loc_en = ~loc_v_q | local_ready;
  assign out_en = ~out_v_q | out_ready;

  assign ic_gnt = loc_gnt[ReqIc] | out_gnt[ReqIc];
  assign dc_gnt = loc_gnt[ReqDc] | out_gnt[ReqDc];

  rr_arb2 u_loc_arb (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (loc_en),
    .req_i  (loc_req),
    .gnt_o  (loc_gnt)
  );

  rr_arb2 u_out_arb (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (out_en),
    .req_i  (out_req),
    .gnt_o  (out_gnt)
  );

  // IC slot: a new pulse may refill the slot in the same edge it is granted away.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ic_v_q   <= 1'b0;
      ic_loc_q <= 1'b0;
      ic_msg_q <= '0;
    end else if (v_ic_req && (!ic_v_q || ic_gnt)) begin
      ic_v_q   <= 1'b1;
      ic_loc_q <= (msg_dest(ic_req_msg) == LOCAL_ID);
      ic_msg_q <= ic_req_msg;
    end else if (ic_gnt) begin
      ic_v_q <= 1'b0;
    end
  end

  // DC slot: same capture/clear rule as the IC slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dc_v_q   <= 1'b0;
      dc_loc_q <= 1'b0;
      dc_msg_q <= '0;
    end else if (v_dc_req && (!dc_v_q || dc_gnt)) begin
      dc_v_q   <= 1'b1;
      dc_loc_q <= (msg_dest(dc_req_msg) == LOCAL_ID);
      dc_msg_q <= dc_req_msg;
    end else if (dc_gnt) begin
      dc_v_q <= 1'b0;
    end
  end

  // Sticky overflow: a pulse hit an occupied slot that was not drained this cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if ((v_ic_req && ic_v_q && !ic_gnt) || (v_dc_req && dc_v_q && !dc_gnt)) begin
      ovf_q <= 1'b1;
    end
  end

  // Local-memory output register; message only changes on a new grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      loc_v_q   <= 1'b0;
      loc_msg_q <= '0;
    end else if (loc_en) begin
      loc_v_q <= |loc_gnt;
      if (loc_gnt[ReqIc]) begin
        loc_msg_q <= ic_msg_q;
      end else if (loc_gnt[ReqDc]) begin
        loc_msg_q <= dc_msg_q;
      end
    end
  end

  // Upload output register; message only changes on a new grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_v_q   <= 1'b0;
      out_msg_q <= '0;
    end else if (out_en) begin
      out_v_q <= |out_gnt;
      if (out_gnt[ReqIc]) begin
        out_msg_q <= ic_msg_q;
      end else if (out_gnt[ReqDc]) begin
        out_msg_q <= dc_msg_q;
      end
    end
  end

  assign v_local_req   = loc_v_q;
  assign local_req_msg = loc_msg_q;
  assign v_out_req     = out_v_q;
  assign out_req_msg   = out_msg_q;
  assign ic_pending    = ic_v_q;
  assign dc_pending    = dc_v_q;
  assign ovf_err       = ovf_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench: directed stimulus pushes expected transfers per channel, a negedge
// monitor pops and compares on every valid&ready; directed checks cover timing and flags.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v_ic_req = 1'b0, v_dc_req = 1'b0;
  logic [47:0] ic_req_msg = '0, dc_req_msg = '0;
  logic        v_local_req, v_out_req;
  logic [47:0] local_req_msg, out_req_msg;
  logic        local_ready = 1'b0, out_ready = 1'b0;
  logic        ic_pending, dc_pending, ovf_err;

  int checks = 0;
  int failures = 0;

  logic [47:0] exp_loc_q[$];
  logic [47:0] exp_out_q[$];

  mem_req_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .v_ic_req      (v_ic_req),
    .ic_req_msg    (ic_req_msg),
    .v_dc_req      (v_dc_req),
    .dc_req_msg    (dc_req_msg),
    .v_local_req   (v_local_req),
    .local_req_msg (local_req_msg),
    .local_ready   (local_ready),
    .v_out_req     (v_out_req),
    .out_req_msg   (out_req_msg),
    .out_ready     (out_ready),
    .ic_pending    (ic_pending),
    .dc_pending    (dc_pending),
    .ovf_err       (ovf_err)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] mk(input logic [1:0] d, input logic [1:0] s,
                                     input logic [4:0] c, input logic [31:0] a);
    return {d, 1'b1, s, 1'b0, c, 5'b00000, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted transfer must match the head of that channel's queue.
  always @(negedge clk) begin
    if (rst) begin
      if (v_local_req && local_ready) begin
        if (exp_loc_q.size() == 0) chk("local_unexpected_xfer", 64'd1, 64'd0);
        else chk("local_xfer_msg", {16'h0, local_req_msg}, {16'h0, exp_loc_q.pop_front()});
      end
      if (v_out_req && out_ready) begin
        if (exp_out_q.size() == 0) chk("out_unexpected_xfer", 64'd1, 64'd0);
        else chk("out_xfer_msg", {16'h0, out_req_msg}, {16'h0, exp_out_q.pop_front()});
      end
    end
  end

  logic [47:0] m1, m2, ma, mb, p1, p2, p3;

  initial begin
    // Reset state
    rst = 1'b0;
    step();
    step();
    chk("rst_v_local", v_local_req, 0);
    chk("rst_v_out", v_out_req, 0);
    chk("rst_local_msg", local_req_msg, 0);
    chk("rst_out_msg", out_req_msg, 0);
    chk("rst_pending", {ic_pending, dc_pending}, 0);
    chk("rst_ovf", ovf_err, 0);
    rst = 1'b1;
    step();

    // Single IC pulse to local: valid exactly at T+2 for one cycle
    local_ready = 1'b1;
    m1 = mk(2'b00, 2'b00, 5'b00110, 32'h0000_1234);
    exp_loc_q.push_back(m1);
    v_ic_req = 1'b1; ic_req_msg = m1;
    step();
    v_ic_req = 1'b0;
    chk("t1_ic_pending_t1", ic_pending, 1);
    chk("t1_v_local_t1", v_local_req, 0);
    step();
    chk("t1_v_local_t2", v_local_req, 1);
    chk("t1_local_msg", local_req_msg, m1);
    chk("t1_v_out", v_out_req, 0);
    chk("t1_ic_pending_t2", ic_pending, 0);
    step();
    chk("t1_v_local_t3", v_local_req, 0);

    // DC pulse to dest 10 with out_ready low: held stable until ready rises
    out_ready = 1'b0;
    m2 = mk(2'b10, 2'b01, 5'b00010, 32'hDEAD_BEE0);
    exp_out_q.push_back(m2);
    v_dc_req = 1'b1; dc_req_msg = m2;
    step();
    v_dc_req = 1'b0;
    chk("t2_dc_pending_t1", dc_pending, 1);
    chk("t2_v_out_t1", v_out_req, 0);
    step();
    chk("t2_v_out_t2", v_out_req, 1);
    chk("t2_dc_pending_t2", dc_pending, 0);
    chk("t2_v_local", v_local_req, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_v_out_hold", v_out_req, 1);
      chk("t2_out_msg_hold", out_req_msg, m2);
    end
    out_ready = 1'b1;
    step();
    chk("t2_v_out_after", v_out_req, 0);

    // Same-cycle IC+DC to local from reset: IC then DC
    rst = 1'b0;
    step();
    rst = 1'b1;
    ma = mk(2'b00, 2'b00, 5'b00110, 32'h0000_0100);
    mb = mk(2'b00, 2'b01, 5'b00001, 32'h0000_0200);
    exp_loc_q.push_back(ma);
    exp_loc_q.push_back(mb);
    v_ic_req = 1'b1; ic_req_msg = ma;
    v_dc_req = 1'b1; dc_req_msg = mb;
    step();
    v_ic_req = 1'b0; v_dc_req = 1'b0;
    step();
    chk("t3_first_ic", local_req_msg, ma);
    step();
    chk("t3_second_dc", local_req_msg, mb);
    step();
    chk("t3_drained", v_local_req, 0);

    // Lone IC grant leaves DC favoured, so the next tie goes DC first
    m1 = mk(2'b00, 2'b00, 5'b00110, 32'h0000_0300);
    exp_loc_q.push_back(m1);
    v_ic_req = 1'b1; ic_req_msg = m1;
    step();
    v_ic_req = 1'b0;
    step();
    step();
    ma = mk(2'b00, 2'b00, 5'b00110, 32'h0000_0400);
    mb = mk(2'b00, 2'b01, 5'b00001, 32'h0000_0500);
    exp_loc_q.push_back(mb);
    exp_loc_q.push_back(ma);
    v_ic_req = 1'b1; ic_req_msg = ma;
    v_dc_req = 1'b1; dc_req_msg = mb;
    step();
    v_ic_req = 1'b0; v_dc_req = 1'b0;
    step();
    chk("t3b_first_dc", local_req_msg, mb);
    step();
    chk("t3b_second_ic", local_req_msg, ma);
    step();

    // IC to local and DC to out together: both valid at T+2
    ma = mk(2'b00, 2'b00, 5'b00110, 32'h0000_0600);
    mb = mk(2'b11, 2'b01, 5'b00001, 32'hCAFE_0700);
    exp_loc_q.push_back(ma);
    exp_out_q.push_back(mb);
    v_ic_req = 1'b1; ic_req_msg = ma;
    v_dc_req = 1'b1; dc_req_msg = mb;
    step();
    v_ic_req = 1'b0; v_dc_req = 1'b0;
    step();
    chk("t4_both_valid", {v_local_req, v_out_req}, 2'b11);
    chk("t4_out_msg", out_req_msg, mb);
    step();

    // Three back-to-back DC pulses into a stalled upload: third dropped, ovf set
    out_ready = 1'b0;
    p1 = mk(2'b01, 2'b01, 5'b00001, 32'h0000_1001);
    p2 = mk(2'b01, 2'b01, 5'b00001, 32'h0000_1002);
    p3 = mk(2'b01, 2'b01, 5'b00001, 32'h0000_1003);
    exp_out_q.push_back(p1);
    exp_out_q.push_back(p2);
    chk("t5_ovf_before", ovf_err, 0);
    v_dc_req = 1'b1; dc_req_msg = p1;
    step();
    dc_req_msg = p2;
    step();
    dc_req_msg = p3;
    step();
    v_dc_req = 1'b0;
    chk("t5_ovf_set", ovf_err, 1);
    chk("t5_dc_pending", dc_pending, 1);
    chk("t5_out_holds_p1", out_req_msg, p1);
    out_ready = 1'b1;
    step();
    chk("t5_out_p2", out_req_msg, p2);
    chk("t5_slot_empty", dc_pending, 0);
    step();
    chk("t5_v_out_done", v_out_req, 0);
    chk("t5_ovf_sticky", ovf_err, 1);
    step();

    // Reset while both outputs are stalled-valid discards everything
    local_ready = 1'b0;
    out_ready = 1'b0;
    v_ic_req = 1'b1; ic_req_msg = mk(2'b00, 2'b00, 5'b00110, 32'h0000_2001);
    v_dc_req = 1'b1; dc_req_msg = mk(2'b10, 2'b01, 5'b00001, 32'h0000_2002);
    step();
    v_ic_req = 1'b0; v_dc_req = 1'b0;
    step();
    chk("t6_both_valid_pre", {v_local_req, v_out_req}, 2'b11);
    rst = 1'b0;
    step();
    chk("t6_rst_valids", {v_local_req, v_out_req}, 0);
    chk("t6_rst_ovf", ovf_err, 0);
    chk("t6_rst_pending", {ic_pending, dc_pending}, 0);
    chk("t6_rst_msgs", {local_req_msg, out_req_msg}, 0);
    rst = 1'b1;
    // Local pointer was left favouring DC; reset must restore IC priority
    local_ready = 1'b1;
    out_ready = 1'b1;
    ma = mk(2'b00, 2'b00, 5'b00110, 32'h0000_3001);
    mb = mk(2'b00, 2'b01, 5'b00001, 32'h0000_3002);
    exp_loc_q.push_back(ma);
    exp_loc_q.push_back(mb);
    v_ic_req = 1'b1; ic_req_msg = ma;
    v_dc_req = 1'b1; dc_req_msg = mb;
    step();
    v_ic_req = 1'b0; v_dc_req = 1'b0;
    step();
    chk("t6_post_rst_ic_first", local_req_msg, ma);
    step();
    chk("t6_post_rst_dc_second", local_req_msg, mb);
    step();
    step();

    chk("end_local_queue_empty", exp_loc_q.size(), 0);
    chk("end_out_queue_empty", exp_out_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
